// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel arbiter.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } dma_state_e;

    localparam int          LEN_W        = 32;
    localparam logic [3:0]  STS_OK       = 4'h0;
    localparam logic [3:0]  STS_ZERO_LEN = 4'h8;

endpackage

// File: rtl/dma_rr_select.sv
// Round-robin selector: the first requester after last_grant (circular) wins.
module dma_rr_select #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W:0] w_cand;

    // Scan from the farthest candidate to the nearest so the nearest requester overwrites.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_cand      = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_cand = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_CH))
                w_cand = w_cand - (IDX_W+1)'(NUM_CH);
            if (req[w_cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Arbitrates NUM_CH descriptor channels onto a single DMA core, one transfer at a time.
module dma_channel_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_req_valid,
    output logic [NUM_CH-1:0]         ch_req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_src_addr,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_dst_addr,
    input  logic [NUM_CH*LEN_W-1:0]   ch_len,
    output logic [NUM_CH-1:0]         ch_done,
    output logic [3:0]                ch_status,
    output logic                      dma_start,
    output logic [ADDR_W-1:0]         dma_src_addr,
    output logic [ADDR_W-1:0]         dma_dst_addr,
    output logic [LEN_W-1:0]          dma_length,
    input  logic                      dma_done,
    input  logic [3:0]                dma_completion_status,
    input  logic                      dma_busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      arb_busy
);

    localparam int IDX_W = $clog2(NUM_CH);

    dma_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_last_grant, r_grant_id;
    logic [ADDR_W-1:0]  r_src, r_dst;
    logic [LEN_W-1:0]   r_len;
    logic [3:0]         r_status;

    logic               w_grant_valid;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_accept;
    logic [LEN_W-1:0]   w_sel_len;

    dma_rr_select #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
        .req         (ch_req_valid),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Grants only happen from IDLE and only while the core reports idle.
    assign w_accept  = (r_state == ST_IDLE) && !dma_busy && w_grant_valid;
    assign w_sel_len = ch_len[w_grant_idx*LEN_W +: LEN_W];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        ch_req_ready = '0;
        ch_done      = '0;
        ch_status    = '0;
        dma_start    = 1'b0;
        arb_busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    ch_req_ready[w_grant_idx] = 1'b1;
                    w_state_nxt = (w_sel_len == '0) ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                dma_start   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (dma_done) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                ch_done[r_grant_id] = 1'b1;
                ch_status           = r_status;
                w_state_nxt         = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Descriptor latch on accept and completion-status capture in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDX_W'(NUM_CH-1);
            r_grant_id   <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_status     <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_idx;
                r_grant_id   <= w_grant_idx;
                r_src        <= ch_src_addr[w_grant_idx*ADDR_W +: ADDR_W];
                r_dst        <= ch_dst_addr[w_grant_idx*ADDR_W +: ADDR_W];
                r_len        <= w_sel_len;
                r_status     <= (w_sel_len == '0) ? STS_ZERO_LEN : STS_OK;
            end
            if (r_state == ST_WAIT && dma_done)
                r_status <= dma_completion_status;
        end
    end

    assign dma_src_addr = r_src;
    assign dma_dst_addr = r_dst;
    assign dma_length   = r_len;
    assign grant_id     = r_grant_id;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed + randomized bench for dma_channel_arbiter with a round-robin reference model.
module tb_dma_channel_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NCH-1:0]     ch_req_valid = '0;
    logic [NCH-1:0]     ch_req_ready;
    logic [NCH*AW-1:0]  src_v = '0;
    logic [NCH*AW-1:0]  dst_v = '0;
    logic [NCH*32-1:0]  len_v = '0;
    logic [NCH-1:0]     ch_done;
    logic [3:0]         ch_status;
    logic               dma_start;
    logic [AW-1:0]      dma_src_addr, dma_dst_addr;
    logic [31:0]        dma_length;
    logic               dma_done = 1'b0;
    logic [3:0]         dma_completion_status = '0;
    logic               dma_busy = 1'b0;
    logic [1:0]         grant_id;
    logic               arb_busy;

    int n_pass  = 0;
    int n_total = 0;
    int last_g  = NCH-1;

    always #5 clk = ~clk;

    dma_channel_arbiter #(.NUM_CH(NCH), .ADDR_W(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ch_req_valid          (ch_req_valid),
        .ch_req_ready          (ch_req_ready),
        .ch_src_addr           (src_v),
        .ch_dst_addr           (dst_v),
        .ch_len                (len_v),
        .ch_done               (ch_done),
        .ch_status             (ch_status),
        .dma_start             (dma_start),
        .dma_src_addr          (dma_src_addr),
        .dma_dst_addr          (dma_dst_addr),
        .dma_length            (dma_length),
        .dma_done              (dma_done),
        .dma_completion_status (dma_completion_status),
        .dma_busy              (dma_busy),
        .grant_id              (grant_id),
        .arb_busy              (arb_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: nearest requesting channel after the last winner, circularly.
    function automatic int rr_pick(input logic [NCH-1:0] v);
        for (int k = 1; k <= NCH; k++) begin
            int c = (last_g + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_desc(input bit allow_zero);
        for (int c = 0; c < NCH; c++) begin
            src_v[c*AW +: AW] = $urandom;
            dst_v[c*AW +: AW] = $urandom;
            if (allow_zero && $urandom_range(0, 3) == 0) len_v[c*32 +: 32] = '0;
            else len_v[c*32 +: 32] = $urandom_range(1, 4096);
        end
    endtask

    // One full arbitration round starting in IDLE, core answers after lat WAIT cycles.
    task automatic run_txn(input int lat, input logic [3:0] sts);
        int w;
        logic [AW-1:0] es, ed;
        logic [31:0]   el;
        @(negedge clk);
        w = rr_pick(ch_req_valid);
        if (w < 0) begin
            chk("idle_no_ready", ch_req_ready, 0);
            chk("idle_not_busy", arb_busy, 0);
            tick();
            return;
        end
        chk("ready_onehot", ch_req_ready, 64'(1 << w));
        es = src_v[w*AW +: AW];
        ed = dst_v[w*AW +: AW];
        el = len_v[w*32 +: 32];
        last_g = w;
        tick();
        rand_desc(0);
        @(negedge clk);
        chk("grant_id", grant_id, w);
        chk("arb_busy", arb_busy, 1);
        chk("no_ready_busy", ch_req_ready, 0);
        if (el == 0) begin
            chk("zl_no_start", dma_start, 0);
            chk("zl_done", ch_done, 64'(1 << w));
            chk("zl_status", ch_status, 4'h8);
            tick();
            return;
        end
        chk("start", dma_start, 1);
        chk("src", dma_src_addr, es);
        chk("dst", dma_dst_addr, ed);
        chk("len", dma_length, el);
        tick();
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("wait_quiet", {dma_start, ch_done, ch_req_ready}, 0);
            tick();
        end
        dma_done = 1'b1;
        dma_completion_status = sts;
        @(negedge clk);
        chk("done_not_yet", ch_done, 0);
        tick();
        dma_done = 1'b0;
        dma_completion_status = 4'($urandom);
        @(negedge clk);
        chk("ch_done", ch_done, 64'(1 << w));
        chk("ch_status", ch_status, sts);
        chk("hold_src", dma_src_addr, es);
        chk("hold_len", dma_length, el);
        chk("resp_no_start", dma_start, 0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int order[5];
        int w;
        order = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {ch_req_ready, ch_done, ch_status, dma_start, grant_id, arb_busy}, 0);
        chk("rst_src", dma_src_addr, 0);
        chk("rst_dst", dma_dst_addr, 0);
        chk("rst_len", dma_length, 0);
        tick();
        rst_n = 1'b1;

        // All channels requesting: strict rotation 0,1,2,3,0
        ch_req_valid = 4'b1111;
        rand_desc(0);
        for (int i = 0; i < 5; i++) begin
            run_txn($urandom_range(0, 3), 4'($urandom));
            chk("rr_order", grant_id, order[i]);
        end

        // Ch2 fixed descriptor, status OK
        ch_req_valid = 4'b0100;
        src_v[2*AW +: AW] = 32'h1000;
        dst_v[2*AW +: AW] = 32'h2000;
        len_v[2*32 +: 32] = 32'h40;
        run_txn(2, 4'h0);
        chk("ch2_owner", grant_id, 2);

        // Ch1 zero-length
        ch_req_valid = 4'b0010;
        len_v[1*32 +: 32] = '0;
        run_txn(0, 4'h0);
        chk("ch1_owner", grant_id, 1);

        // Core busy blocks granting
        ch_req_valid = 4'b0001;
        dma_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("busy_no_ready", ch_req_ready, 0);
            chk("busy_idle", arb_busy, 0);
            tick();
        end
        dma_busy = 1'b0;
        run_txn(1, 4'h3);

        // Stray dma_done in IDLE
        ch_req_valid = '0;
        dma_done = 1'b1;
        dma_completion_status = 4'h5;
        @(negedge clk);
        chk("stray_idle", arb_busy, 0);
        tick();
        dma_done = 1'b0;
        @(negedge clk);
        chk("stray_no_done", {ch_done, arb_busy}, 0);
        tick();

        // Randomized traffic, including zero-length and empty request masks
        for (int i = 0; i < 30; i++) begin
            ch_req_valid = 4'($urandom_range(0, 15));
            rand_desc(1);
            run_txn($urandom_range(0, 4), 4'($urandom));
        end

        // Reset during WAIT abandons the transfer
        ch_req_valid = 4'b1000;
        rand_desc(0);
        @(negedge clk);
        w = rr_pick(ch_req_valid);
        chk("pre_rst_ready", ch_req_ready, 64'(1 << w));
        tick();
        tick();
        @(negedge clk);
        chk("in_wait", {arb_busy, dma_start}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {arb_busy, ch_done, grant_id}, 0);
        chk("rst_mid_src", dma_src_addr, 0);
        last_g = NCH-1;
        ch_req_valid = '0;
        tick();
        rst_n = 1'b1;
        dma_done = 1'b1;
        dma_completion_status = 4'hF;
        @(negedge clk);
        chk("late_done_ignored", {ch_done, arb_busy}, 0);
        tick();
        dma_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {ch_done, arb_busy}, 0);
            tick();
        end
        ch_req_valid = 4'b1111;
        run_txn(0, 4'h1);
        chk("post_rst_first", grant_id, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
